// File: rtl/cpu_pkg.sv
// Encodings and defaults shared between the multicycle CPU and its unified memory.
package cpu_pkg;

    localparam int unsigned MEM_ADDR_W = 12;
    localparam int unsigned MEM_DATA_W = 32;

    localparam logic read_from_mem = 1'b0;
    localparam logic write_to_mem  = 1'b1;

    typedef enum logic {
        IDLE,
        CLEAR
    } mem_state_t;

endpackage

// File: rtl/cpu_memory_if.sv
// CPU-side single-port memory bus: request, address, write data and returned read data.
interface cpu_memory_if #(
    parameter int unsigned ADDR_W = cpu_pkg::MEM_ADDR_W,
    parameter int unsigned DATA_W = cpu_pkg::MEM_DATA_W
) ();

    logic              mem_en;
    logic              read_write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output mem_en,
        output read_write,
        output address,
        output wr_data,
        input  rd_data
    );

    modport slave (
        input  mem_en,
        input  read_write,
        input  address,
        input  wr_data,
        output rd_data
    );

endinterface

// File: rtl/mem_array.sv
// Falling-edge storage array: one combinational read port, two write ports where port b
// overrides port a when both hit the same word on the same edge.
module mem_array #(
    parameter int unsigned ADDR_W = cpu_pkg::MEM_ADDR_W,
    parameter int unsigned DATA_W = cpu_pkg::MEM_DATA_W
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    assign rd_data = mem[rd_addr];

    // Later non-blocking assignment wins, giving port b priority on a collision.
    always_ff @(negedge clk) begin
        if (wa_en) begin
            mem[wa_addr] <= wa_data;
        end
        if (wb_en) begin
            mem[wb_addr] <= wb_data;
        end
    end

endmodule

// File: rtl/cpu_memory.sv
// Unified CPU instruction/data memory with a one-word-per-cycle clear sweep and a preload port.
// Everything updates on the falling edge so read data is settled for the CPU's next rising edge.
module cpu_memory
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
) (
    input  logic              clk_in,
    input  logic              reset_n,
    cpu_memory_if.slave       bus,
    input  logic              clr_mem,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              busy,
    output logic              access_err
);

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              clr_prev_q;
    logic              err_q, err_d;

    logic [DATA_W-1:0] arr_rd;
    logic              wa_en, wb_en;
    logic [ADDR_W-1:0] wa_addr, wb_addr;
    logic [DATA_W-1:0] wa_data, wb_data;

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk     (clk_in),
        .rd_addr (bus.address),
        .rd_data (arr_rd),
        .wa_en   (wa_en),
        .wa_addr (wa_addr),
        .wa_data (wa_data),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        err_d     = err_q;
        wa_en     = 1'b0;
        wa_addr   = bus.address;
        wa_data   = bus.wr_data;
        wb_en     = 1'b0;
        wb_addr   = ld_addr;
        wb_data   = ld_data;

        unique case (state_q)
            IDLE: begin
                if (clr_mem && !clr_prev_q) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
                if (bus.mem_en) begin
                    if (bus.read_write == write_to_mem) begin
                        wa_en     = 1'b1;
                        rd_data_d = bus.wr_data;
                    end else begin
                        // Array read is combinational, so a same-edge preload is not yet visible.
                        rd_data_d = arr_rd;
                    end
                end
                wb_en = ld_en;
            end
            CLEAR: begin
                // The sweep owns port a; CPU writes and preloads are dropped.
                wa_en   = 1'b1;
                wa_addr = cnt_q;
                wa_data = '0;
                cnt_d   = cnt_q + ADDR_W'(1);
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = IDLE;
                end
                if (bus.mem_en && bus.read_write == read_from_mem) begin
                    rd_data_d = '0;
                end
                if (bus.mem_en || ld_en) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            clr_prev_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            clr_prev_q <= clr_mem;
            err_q      <= err_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign busy        = (state_q == CLEAR);
    assign access_err  = err_q;

endmodule

// File: tb/tb_cpu_memory.sv
// Directed bench for cpu_memory with a 16-word array; expected values are hand-computed.
module tb_cpu_memory;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;

    logic          clk_in;
    logic          reset_n;
    logic          clr_mem;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          busy;
    logic          access_err;

    int checks;
    int errors;
    int busy_edges;

    cpu_memory_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    cpu_memory #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .bus        (bus),
        .clr_mem    (clr_mem),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .busy       (busy),
        .access_err (access_err)
    );

    initial clk_in = 1'b1;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next falling edge; outputs are sampled and inputs changed 1ns later.
    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    task automatic bus_idle();
        bus.mem_en     = 1'b0;
        bus.read_write = 1'b0;
        ld_en          = 1'b0;
    endtask

    task automatic cpu_read(input logic [AW-1:0] a);
        bus.mem_en     = 1'b1;
        bus.read_write = 1'b0;
        bus.address    = a;
        step();
        bus_idle();
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.mem_en     = 1'b1;
        bus.read_write = 1'b1;
        bus.address    = a;
        bus.wr_data    = d;
        step();
        bus_idle();
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset_n        = 1'b0;
        clr_mem        = 1'b0;
        ld_en          = 1'b0;
        ld_addr        = '0;
        ld_data        = '0;
        bus.mem_en     = 1'b0;
        bus.read_write = 1'b0;
        bus.address    = '0;
        bus.wr_data    = '0;

        #2;
        check("reset_rd_data", bus.rd_data, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_access_err", {31'b0, access_err}, 32'h0);
        #1 reset_n = 1'b1;
        step();

        // Preload then CPU read
        preload(4'd3, 32'h1234_5678);
        check("preload_no_rd_effect", bus.rd_data, 32'h0);
        cpu_read(4'd3);
        check("read_preloaded_3", bus.rd_data, 32'h1234_5678);
        check("no_err_after_read", {31'b0, access_err}, 32'h0);

        // CPU write-through, then reads of other and same word
        cpu_write(4'd15, 32'hDEAD_BEEF);
        check("write_through_15", bus.rd_data, 32'hDEAD_BEEF);
        cpu_read(4'd3);
        check("read_3_again", bus.rd_data, 32'h1234_5678);
        cpu_read(4'd15);
        check("read_written_15", bus.rd_data, 32'hDEAD_BEEF);

        // Idle bus holds rd_data
        bus.address = 4'd3;
        step();
        check("idle_hold", bus.rd_data, 32'hDEAD_BEEF);

        // Same-address collision: preload wins in the array, CPU sees its own write-through
        ld_en = 1'b1; ld_addr = 4'd7; ld_data = 32'h1111;
        cpu_write(4'd7, 32'h2222);
        check("collision_write_through", bus.rd_data, 32'h2222);
        cpu_read(4'd7);
        check("collision_preload_wins", bus.rd_data, 32'h1111);

        // Different addresses: both commit
        ld_en = 1'b1; ld_addr = 4'd8; ld_data = 32'h8888;
        cpu_write(4'd9, 32'h9999);
        cpu_read(4'd8);
        check("dual_write_8", bus.rd_data, 32'h8888);
        cpu_read(4'd9);
        check("dual_write_9", bus.rd_data, 32'h9999);

        // Read during preload to same word returns old contents
        ld_en = 1'b1; ld_addr = 4'd3; ld_data = 32'h3333_3333;
        cpu_read(4'd3);
        check("read_before_write", bus.rd_data, 32'h1234_5678);
        cpu_read(4'd3);
        check("read_after_preload", bus.rd_data, 32'h3333_3333);

        // Full clear with mid-sweep accesses; clr_mem held high throughout
        for (int i = 0; i < 16; i++) begin
            preload(AW'(i), 32'hA000_0000 + 32'(i));
        end
        clr_mem = 1'b1;
        step();
        check("clear_busy_rise", {31'b0, busy}, 32'h1);
        busy_edges = 1;
        bus.mem_en = 1'b1; bus.read_write = 1'b0; bus.address = 4'd5;
        step();
        if (busy) busy_edges++;
        check("clear_read_zero", bus.rd_data, 32'h0);
        check("clear_access_err", {31'b0, access_err}, 32'h1);
        bus.read_write = 1'b1; bus.address = 4'd14; bus.wr_data = 32'hAAAA;
        step();
        if (busy) busy_edges++;
        bus_idle();
        for (int i = 0; i < 17; i++) begin
            step();
            if (busy) busy_edges++;
        end
        check("clear_busy_edges", 32'(busy_edges), 32'd16);
        check("clear_no_retrigger", {31'b0, busy}, 32'h0);
        clr_mem = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cpu_read(AW'(i));
            check($sformatf("cleared_%0d", i), bus.rd_data, 32'h0);
        end
        check("access_err_sticky", {31'b0, access_err}, 32'h1);

        // Reset in the middle of a sweep
        for (int i = 0; i < 16; i++) begin
            preload(AW'(i), 32'hB000_0000 + 32'(i));
        end
        cpu_read(4'd15);
        check("refill_read_15", bus.rd_data, 32'hB000_000F);
        clr_mem = 1'b1;
        step();
        clr_mem = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
        end
        check("busy_before_reset", {31'b0, busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("midclear_reset_busy", {31'b0, busy}, 32'h0);
        check("midclear_reset_rd_data", bus.rd_data, 32'h0);
        check("midclear_reset_err", {31'b0, access_err}, 32'h0);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cpu_read(AW'(i));
            check($sformatf("partial_%0d", i), bus.rd_data,
                  (i < 6) ? 32'h0 : 32'hB000_0000 + 32'(i));
        end
        check("no_busy_after_reset", {31'b0, busy}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
